// File: rtl/usb_link_ctrl_p.sv
// USB link-layer transaction controller: sequences token/data/handshake phases in master or slave mode.
// Optional hardware retry accounting is built when LINK_RETRY_EN is defined.
module usb_link_ctrl_p #(
    parameter int TIMER_W = 16,
    parameter int DELAY_W = 6,
    parameter int RETRY_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ms,
    input  logic               rx_pid_en,
    input  logic [3:0]         rx_pid,
    input  logic               crc5_err,
    input  logic               rx_sop_en,
    input  logic               rx_lt_eop_en,
    input  logic               crc16_err,
    input  logic               tx_con_pid_en,
    input  logic [3:0]         tx_con_pid,
    input  logic               tx_lp_eop_en,
    input  logic [TIMER_W-1:0] time_threshold,
    input  logic [DELAY_W-1:0] delay_threshold,
    input  logic [RETRY_W-1:0] max_retry,
    input  logic               time_out_clr,
    output logic               rx_data_on,
    output logic               rx_handshake_on,
    output logic               tx_data_on,
    output logic               tx_hs_on,
    output logic               d_oe,
    output logic               time_out,
    output logic [1:0]         hs_result,
    output logic               busy,
    output logic               retry_req,
    output logic               retry_exhausted
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        S_IDLE, S_TOK, S_TX_DATA, S_RX_WAIT, S_RX_DATA, S_TX_HS, S_TURN, S_HS_WAIT
    } state_t;

    state_t             state_q, state_d, ret_q, ret_d;
    logic               ms_q, ms_d;
    logic               tok_in_q, tok_in_d;
    logic [TIMER_W-1:0] timer_q;
    logic [DELAY_W-1:0] turn_cnt_q;
    logic               d_oe_q;
    logic               start, tmo_hit, hs_valid, rx_tok, wait_match;
    logic [1:0]         hs_code;

    assign rx_tok     = rx_pid_en & ~crc5_err;
    assign wait_match = (timer_q == time_threshold);

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        ms_d     = ms_q;
        tok_in_d = tok_in_q;
        start    = 1'b0;
        tmo_hit  = 1'b0;
        hs_valid = 1'b0;
        hs_code  = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (ms) begin
                    if (tx_con_pid_en && (tx_con_pid == PID_OUT || tx_con_pid == PID_IN)) begin
                        state_d  = S_TOK;
                        tok_in_d = (tx_con_pid == PID_IN);
                        ms_d     = 1'b1;
                        start    = 1'b1;
                    end
                end else if (rx_tok && rx_pid == PID_IN) begin
                    state_d = S_TX_DATA;
                    ms_d    = 1'b0;
                    start   = 1'b1;
                end else if (rx_tok && rx_pid == PID_OUT) begin
                    state_d = S_RX_WAIT;
                    ms_d    = 1'b0;
                    start   = 1'b1;
                end
            end
            S_TOK: begin
                if (tx_lp_eop_en) begin
                    if (tok_in_q) begin
                        state_d = S_TURN;
                        ret_d   = S_RX_WAIT;
                    end else begin
                        state_d = S_TX_DATA;
                    end
                end
            end
            S_TX_DATA: begin
                if (tx_lp_eop_en) begin
                    state_d = S_TURN;
                    ret_d   = S_HS_WAIT;
                end
            end
            S_RX_WAIT: begin
                // A start-of-packet on the matching cycle beats the timeout.
                if (rx_sop_en) begin
                    state_d = S_RX_DATA;
                end else if (wait_match) begin
                    state_d = S_IDLE;
                    tmo_hit = 1'b1;
                end
            end
            S_RX_DATA: begin
                if (rx_lt_eop_en) begin
                    if (!crc16_err) begin
                        state_d = S_TX_HS;
                    end else if (ms_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_TURN;
                        ret_d   = S_IDLE;
                    end
                end
            end
            S_TX_HS: begin
                if (tx_lp_eop_en) begin
                    if (ms_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_TURN;
                        ret_d   = S_IDLE;
                    end
                end
            end
            S_TURN: begin
                if (turn_cnt_q == delay_threshold) state_d = ret_q;
            end
            S_HS_WAIT: begin
                if (rx_tok && (rx_pid == PID_ACK || rx_pid == PID_NAK || rx_pid == PID_STALL)) begin
                    hs_valid = 1'b1;
                    hs_code  = (rx_pid == PID_ACK) ? 2'b01 : (rx_pid == PID_NAK) ? 2'b10 : 2'b11;
                    state_d  = S_IDLE;
                end else if (wait_match) begin
                    state_d = S_IDLE;
                    tmo_hit = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            ret_q           <= S_IDLE;
            ms_q            <= 1'b0;
            tok_in_q        <= 1'b0;
            timer_q         <= '0;
            turn_cnt_q      <= '0;
            d_oe_q          <= 1'b0;
            rx_data_on      <= 1'b0;
            rx_handshake_on <= 1'b0;
            tx_data_on      <= 1'b0;
            tx_hs_on        <= 1'b0;
            busy            <= 1'b0;
            time_out        <= 1'b0;
            hs_result       <= 2'b00;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            ms_q     <= ms_d;
            tok_in_q <= tok_in_d;

            if (state_q == S_TURN && state_d == S_TURN) turn_cnt_q <= turn_cnt_q + 1'b1;
            else                                        turn_cnt_q <= '0;

            // Timer restarts on wait-state entry and saturates instead of wrapping.
            if ((state_d == S_RX_WAIT || state_d == S_HS_WAIT) && state_d != state_q)
                timer_q <= '0;
            else if ((state_q == S_RX_WAIT || state_q == S_HS_WAIT) && timer_q != '1)
                timer_q <= timer_q + 1'b1;

            case (state_d)
                S_TOK, S_TX_DATA, S_TX_HS: d_oe_q <= 1'b1;
                S_TURN:                    d_oe_q <= d_oe_q;
                default:                   d_oe_q <= 1'b0;
            endcase

            rx_data_on      <= (state_d == S_RX_WAIT) || (state_d == S_RX_DATA);
            rx_handshake_on <= (state_d == S_HS_WAIT);
            tx_data_on      <= (state_d == S_TX_DATA);
            tx_hs_on        <= (state_d == S_TX_HS);
            busy            <= (state_d != S_IDLE);

            if (start)         hs_result <= 2'b00;
            else if (hs_valid) hs_result <= hs_code;

            if (tmo_hit)                    time_out <= 1'b1;
            else if (time_out_clr || start) time_out <= 1'b0;
        end
    end

    assign d_oe = (state_q == S_IDLE) ? ms : d_oe_q;

`ifdef LINK_RETRY_EN
    logic [RETRY_W-1:0] retry_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt_q     <= '0;
            retry_req       <= 1'b0;
            retry_exhausted <= 1'b0;
        end else begin
            retry_req <= 1'b0;
            if (ms_q && (tmo_hit || (hs_valid && hs_code == 2'b10))) begin
                if (retry_cnt_q == max_retry) begin
                    retry_exhausted <= 1'b1;
                end else begin
                    retry_req   <= 1'b1;
                    retry_cnt_q <= retry_cnt_q + 1'b1;
                end
            end else if ((hs_valid && hs_code != 2'b10) || time_out_clr) begin
                retry_cnt_q     <= '0;
                retry_exhausted <= 1'b0;
            end
        end
    end
`else
    logic unused_retry;
    assign unused_retry    = ^max_retry;
    assign retry_req       = 1'b0;
    assign retry_exhausted = 1'b0;
`endif

endmodule

// File: tb/tb_usb_link_ctrl_p.sv
// Directed/randomized bench for usb_link_ctrl_p with a transaction-level reference model.
module tb_usb_link_ctrl_p;

    localparam int TIMER_W = 16;
    localparam int DELAY_W = 6;
    localparam int RETRY_W = 3;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    logic clk = 1'b0;
    logic rst_n;
    logic ms, rx_pid_en, crc5_err, rx_sop_en, rx_lt_eop_en, crc16_err;
    logic tx_con_pid_en, tx_lp_eop_en, time_out_clr;
    logic [3:0] rx_pid, tx_con_pid;
    logic [TIMER_W-1:0] time_threshold;
    logic [DELAY_W-1:0] delay_threshold;
    logic [RETRY_W-1:0] max_retry;
    logic rx_data_on, rx_handshake_on, tx_data_on, tx_hs_on, d_oe, time_out, busy;
    logic retry_req, retry_exhausted;
    logic [1:0] hs_result;

    int checks = 0;
    int errors = 0;

    usb_link_ctrl_p #(.TIMER_W(TIMER_W), .DELAY_W(DELAY_W), .RETRY_W(RETRY_W)) dut (
        .clk(clk), .rst_n(rst_n), .ms(ms), .rx_pid_en(rx_pid_en), .rx_pid(rx_pid),
        .crc5_err(crc5_err), .rx_sop_en(rx_sop_en), .rx_lt_eop_en(rx_lt_eop_en),
        .crc16_err(crc16_err), .tx_con_pid_en(tx_con_pid_en), .tx_con_pid(tx_con_pid),
        .tx_lp_eop_en(tx_lp_eop_en), .time_threshold(time_threshold),
        .delay_threshold(delay_threshold), .max_retry(max_retry), .time_out_clr(time_out_clr),
        .rx_data_on(rx_data_on), .rx_handshake_on(rx_handshake_on), .tx_data_on(tx_data_on),
        .tx_hs_on(tx_hs_on), .d_oe(d_oe), .time_out(time_out), .hs_result(hs_result),
        .busy(busy), .retry_req(retry_req), .retry_exhausted(retry_exhausted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: handshake PID to result code.
    function automatic logic [1:0] hs_of(input logic [3:0] pid);
        case (pid)
            PID_ACK:   return 2'b01;
            PID_NAK:   return 2'b10;
            PID_STALL: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    task automatic pulse_tx_eop();
        tx_lp_eop_en = 1'b1; step(); tx_lp_eop_en = 1'b0;
    endtask

    task automatic pulse_sop();
        rx_sop_en = 1'b1; step(); rx_sop_en = 1'b0;
    endtask

    task automatic send_pid(input logic [3:0] pid, input logic err);
        rx_pid = pid; crc5_err = err; rx_pid_en = 1'b1;
        step();
        rx_pid_en = 1'b0; crc5_err = 1'b0;
    endtask

    task automatic send_data_eop(input logic err);
        crc16_err = err; rx_lt_eop_en = 1'b1;
        step();
        rx_lt_eop_en = 1'b0; crc16_err = 1'b0;
    endtask

    // Turnaround must last delay+1 cycles with no engine enabled and d_oe held.
    task automatic wait_turn(input string tag, input int d, input logic exp_doe);
        int n = 0;
        int bad_doe = 0;
        while (busy && !tx_data_on && !tx_hs_on && !rx_data_on && !rx_handshake_on && n < 200) begin
            if (d_oe !== exp_doe) bad_doe++;
            n++;
            step();
        end
        chk({tag, "_turn_len"}, n, d + 1);
        chk({tag, "_turn_doe"}, bad_doe, 0);
    endtask

    // A wait state with no response must time out after threshold+1 cycles.
    task automatic wait_timeout(input string tag, input int thr, input bit rx);
        int n = 0;
        while ((rx ? rx_data_on : rx_handshake_on) && n < 5000) begin
            n++;
            step();
        end
        chk({tag, "_wait_len"}, n, thr + 1);
        chk({tag, "_time_out"}, time_out, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic master_out_to_hs(input string tag, input int d);
        delay_threshold = DELAY_W'(d);
        ms = 1'b1; tx_con_pid = PID_OUT; tx_con_pid_en = 1'b1;
        step();
        tx_con_pid_en = 1'b0;
        chk({tag, "_tok_busy"}, busy, 1);
        chk({tag, "_tok_doe"}, d_oe, 1);
        chk({tag, "_hs_clr"}, hs_result, 0);
        repeat ($urandom_range(3, 0)) step();
        pulse_tx_eop();
        chk({tag, "_txdata"}, tx_data_on, 1);
        repeat ($urandom_range(4, 0)) step();
        chk({tag, "_txdata_hold"}, {tx_data_on, d_oe}, 2'b11);
        pulse_tx_eop();
        wait_turn(tag, d, 1'b1);
        chk({tag, "_hswait"}, {rx_handshake_on, d_oe}, 2'b10);
    endtask

    task automatic master_in_to_rx(input string tag, input int d);
        delay_threshold = DELAY_W'(d);
        ms = 1'b1; tx_con_pid = PID_IN; tx_con_pid_en = 1'b1;
        step();
        tx_con_pid_en = 1'b0;
        chk({tag, "_tok_busy"}, busy, 1);
        chk({tag, "_tok_timeout_clr"}, time_out, 0);
        pulse_tx_eop();
        wait_turn(tag, d, 1'b1);
        chk({tag, "_rxwait"}, {rx_data_on, d_oe}, 2'b10);
    endtask

    int d, thr, w;
    logic [3:0] pid;
    logic e;
    int rcnt;
    logic exp_req, exp_ex;
    logic [3:0] hs_pids [3] = '{PID_ACK, PID_NAK, PID_STALL};

    initial begin
        rst_n = 1'b0; ms = 1'b1;
        rx_pid_en = 0; rx_pid = 0; crc5_err = 0; rx_sop_en = 0; rx_lt_eop_en = 0; crc16_err = 0;
        tx_con_pid_en = 0; tx_con_pid = 0; tx_lp_eop_en = 0; time_out_clr = 0;
        time_threshold = 20; delay_threshold = 3; max_retry = 2;

        // Reset state
        #12;
        chk("rst_enables", {rx_data_on, rx_handshake_on, tx_data_on, tx_hs_on}, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {time_out, hs_result, retry_req, retry_exhausted}, 5'b0);
        chk("rst_doe_ms1", d_oe, 1);
        ms = 1'b0; #1;
        chk("rst_doe_ms0", d_oe, 0);
        ms = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Master OUT, delay 3, ACK in the 10th handshake-wait cycle
        master_out_to_hs("mo_spec", 3);
        repeat (9) step();
        chk("mo_spec_still_wait", rx_handshake_on, 1);
        send_pid(PID_ACK, 1'b0);
        chk("mo_spec_hs", hs_result, 2'b01);
        chk("mo_spec_done", {busy, rx_handshake_on, d_oe}, 3'b001);

        // Randomized master OUT transactions with ignored PIDs sprinkled in
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(7, 0);
            thr = $urandom_range(30, 8);
            time_threshold = TIMER_W'(thr);
            pid = hs_pids[$urandom_range(2, 0)];
            master_out_to_hs("mo_rand", d);
            w = $urandom_range(thr - 3, 0);
            repeat (w) step();
            if (i % 2 == 0) send_pid(PID_IN, 1'b0);
            else            send_pid(PID_ACK, 1'b1);
            chk("mo_rand_ignored", {rx_handshake_on, busy}, 2'b11);
            send_pid(pid, 1'b0);
            chk("mo_rand_hs", hs_result, hs_of(pid));
            chk("mo_rand_idle", {busy, rx_handshake_on}, 2'b00);
        end

        // Master OUT timeout with threshold 20, then explicit clear
        time_threshold = 20;
        master_out_to_hs("mo_tmo", 3);
        wait_timeout("mo_tmo", 20, 1'b0);
        step();
        chk("mo_tmo_sticky", time_out, 1);
        time_out_clr = 1'b1; step(); time_out_clr = 1'b0;
        chk("mo_tmo_clr", time_out, 0);

        // Leave a timeout pending so the next transaction start must clear it
        master_out_to_hs("mo_tmo2", 0);
        wait_timeout("mo_tmo2", 20, 1'b0);

        // Master IN, good data then CRC-errored data, then random
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(5, 0);
            e = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(1, 0));
            master_in_to_rx("mi", d);
            repeat ($urandom_range(10, 0)) step();
            pulse_sop();
            chk("mi_rxdata", {rx_data_on, busy}, 2'b11);
            repeat (22) step();
            chk("mi_rxdata_no_tmo", {rx_data_on, time_out}, 2'b10);
            send_data_eop(e);
            if (!e) begin
                chk("mi_txhs", {tx_hs_on, d_oe, busy, rx_data_on}, 4'b1110);
                pulse_tx_eop();
                chk("mi_done", {busy, tx_hs_on, d_oe}, 3'b001);
            end else begin
                chk("mi_crcerr_idle", {busy, tx_hs_on, rx_data_on}, 3'b000);
            end
        end

        // Start-of-packet on the exact timeout cycle wins
        thr = $urandom_range(10, 1);
        time_threshold = TIMER_W'(thr);
        master_in_to_rx("mi_race", 1);
        repeat (thr) step();
        pulse_sop();
        chk("mi_race_sop_wins", {rx_data_on, time_out, busy}, 3'b101);
        send_data_eop(1'b1);
        chk("mi_race_idle", busy, 0);

        // Zero threshold times out on the first wait cycle; set beats simultaneous clear
        time_threshold = 0;
        master_in_to_rx("mi_t0", 2);
        time_out_clr = 1'b1;
        wait_timeout("mi_t0", 0, 1'b1);
        step();
        time_out_clr = 1'b0;
        chk("mi_t0_clr_after", time_out, 0);
        time_threshold = 40;

        // Slave IN: errored token ignored, good token starts data; live ms/tokens ignored while busy
        d = $urandom_range(6, 0);
        delay_threshold = DELAY_W'(d);
        ms = 1'b0;
        send_pid(PID_IN, 1'b1);
        chk("si_crc5_ignored", {busy, tx_data_on}, 2'b00);
        send_pid(PID_IN, 1'b0);
        chk("si_txdata", {tx_data_on, d_oe, busy}, 3'b111);
        ms = 1'b1;
        tx_con_pid = PID_OUT; tx_con_pid_en = 1'b1; step(); tx_con_pid_en = 1'b0;
        chk("si_token_ignored", {tx_data_on, busy}, 2'b11);
        pulse_tx_eop();
        wait_turn("si", d, 1'b1);
        chk("si_hswait", {rx_handshake_on, d_oe}, 2'b10);
        send_pid(PID_NAK, 1'b0);
        chk("si_hs", hs_result, 2'b10);
        chk("si_no_retry", retry_req, 0);
        chk("si_idle_doe_ms", {busy, d_oe}, 2'b01);
        ms = 1'b0;

        // Slave OUT, good then CRC-errored data
        for (int i = 0; i < 2; i++) begin
            d = $urandom_range(6, 0);
            delay_threshold = DELAY_W'(d);
            e = 1'(i);
            send_pid(PID_OUT, 1'b0);
            chk("so_rxwait", {rx_data_on, d_oe, busy}, 3'b101);
            repeat ($urandom_range(8, 0)) step();
            pulse_sop();
            chk("so_rxdata", rx_data_on, 1);
            send_data_eop(e);
            if (!e) begin
                chk("so_txhs", {tx_hs_on, d_oe}, 2'b11);
                pulse_tx_eop();
                wait_turn("so", d, 1'b1);
            end else begin
                chk("so_crcerr_skip", {tx_hs_on, busy, rx_data_on}, 3'b010);
                wait_turn("so_err", d, 1'b0);
            end
            chk("so_done", {busy, d_oe}, 2'b00);
        end

        // Retry accounting over three NAKs, cleared by ACK
        ms = 1'b1;
        time_threshold = 40;
        time_out_clr = 1'b1; step(); time_out_clr = 1'b0;
        rcnt = 0;
        exp_ex = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pid = (i < 3) ? PID_NAK : PID_ACK;
            master_out_to_hs("rt", $urandom_range(3, 0));
            repeat ($urandom_range(5, 0)) step();
            send_pid(pid, 1'b0);
            exp_req = 1'b0;
`ifdef LINK_RETRY_EN
            if (pid == PID_NAK) begin
                if (rcnt == int'(max_retry)) exp_ex = 1'b1;
                else begin exp_req = 1'b1; rcnt++; end
            end else begin
                rcnt = 0; exp_ex = 1'b0;
            end
`endif
            chk("rt_req", retry_req, exp_req);
            chk("rt_exhausted", retry_exhausted, exp_ex);
            step();
            chk("rt_req_pulse", retry_req, 0);
        end

        // Asynchronous reset in the middle of a data receive
        time_threshold = 40;
        master_in_to_rx("mr", 1);
        pulse_sop();
        chk("mr_rxdata", rx_data_on, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mr_rst_enables", {rx_data_on, rx_handshake_on, tx_data_on, tx_hs_on, busy}, 5'b0);
        chk("mr_rst_doe1", d_oe, 1);
        ms = 1'b0; #1;
        chk("mr_rst_doe0", d_oe, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("mr_after_rst_idle", {busy, rx_data_on}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
